// File: rtl/seq_det_sched_if.sv
// rtl/seq_det_sched_if.sv - request/data/grant bundle between the two serial sources and the scheduler
interface seq_det_sched_if;
  logic req0;
  logic x0;
  logic req1;
  logic x1;
  logic gnt0;
  logic gnt1;

  // Sources drive request and data; the scheduler answers with grants.
  modport master (
    output req0, x0, req1, x1,
    input  gnt0, gnt1
  );

  modport slave (
    input  req0, x0, req1, x1,
    output gnt0, gnt1
  );
endinterface

// File: rtl/seq_det_sched.sv
// rtl/seq_det_sched.sv - round-robin scheduler sharing one sequence detector between two serial channels
module seq_det_sched #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1110,
  parameter int                 CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  seq_det_sched_if.slave   bus,
  input  logic             clear,
  output logic             z0,
  output logic             z1,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam int                FILL_W   = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } last_e;

  last_e              last_q, last_d;
  logic [1:0]         req, x, gnt, match;
  logic [1:0]         z_q;
  logic [PAT_LEN-1:0] win    [2];
  logic [PAT_LEN-2:0] hist_q [2];
  logic [PAT_LEN-2:0] hist_d [2];
  logic [FILL_W-1:0]  fill_q [2];
  logic [FILL_W-1:0]  fill_d [2];
  logic [CNT_W-1:0]   cnt_q  [2];
  logic [CNT_W-1:0]   cnt_d  [2];

  assign req = {bus.req1, bus.req0};
  assign x   = {bus.x1, bus.x0};

  // Under contention the channel the pointer does not name wins.
  assign gnt[0] = req[0] & (~req[1] | (last_q == LAST1));
  assign gnt[1] = req[1] & (~req[0] | (last_q == LAST0));

  assign bus.gnt0 = gnt[0];
  assign bus.gnt1 = gnt[1];

  always_comb begin
    last_d = last_q;
    if (gnt[0]) begin
      last_d = LAST0;
    end else if (gnt[1]) begin
      last_d = LAST1;
    end
    for (int c = 0; c < 2; c++) begin
      win[c]    = {hist_q[c], x[c]};
      // The fill guard keeps the zero history left by reset from matching.
      match[c]  = gnt[c] && (win[c] == PATTERN) && (fill_q[c] == FILL_MAX);
      hist_d[c] = hist_q[c];
      fill_d[c] = fill_q[c];
      if (gnt[c]) begin
        hist_d[c] = win[c][PAT_LEN-2:0];
        if (fill_q[c] != FILL_MAX) begin
          fill_d[c] = fill_q[c] + FILL_W'(1);
        end
      end
      cnt_d[c] = cnt_q[c];
      if (clear) begin
        cnt_d[c] = '0;
      end else if (match[c] && (cnt_q[c] != {CNT_W{1'b1}})) begin
        cnt_d[c] = cnt_q[c] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= LAST1;
      z_q    <= '0;
      for (int c = 0; c < 2; c++) begin
        hist_q[c] <= '0;
        fill_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
    end else begin
      last_q <= last_d;
      z_q    <= match;
      for (int c = 0; c < 2; c++) begin
        hist_q[c] <= hist_d[c];
        fill_q[c] <= fill_d[c];
        cnt_q[c]  <= cnt_d[c];
      end
    end
  end

  assign z0   = z_q[0];
  assign z1   = z_q[1];
  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];

endmodule

// File: tb/tb_seq_det_sched.sv
// tb/tb_seq_det_sched.sv - directed vector bench for seq_det_sched
module tb_seq_det_sched;

  logic clk = 1'b0;
  logic rst, req0, x0, req1, x1, clr;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  seq_det_sched_if ifa ();
  seq_det_sched_if ifg ();
  seq_det_sched_if ifs ();

  assign ifa.req0 = req0; assign ifa.x0 = x0; assign ifa.req1 = req1; assign ifa.x1 = x1;
  assign ifg.req0 = req0; assign ifg.x0 = x0; assign ifg.req1 = req1; assign ifg.x1 = x1;
  assign ifs.req0 = req0; assign ifs.x0 = x0; assign ifs.req1 = req1; assign ifs.x1 = x1;

  logic       za0, za1, zg0, zg1, zs0, zs1;
  logic [7:0] ca0, ca1, cg0, cg1;
  logic [1:0] cs0, cs1;

  seq_det_sched u_a (
    .clock(clk), .reset(rst), .bus(ifa), .clear(clr),
    .z0(za0), .z1(za1), .cnt0(ca0), .cnt1(ca1)
  );

  seq_det_sched #(.PAT_LEN(4), .PATTERN(4'b0001), .CNT_W(8)) u_g (
    .clock(clk), .reset(rst), .bus(ifg), .clear(clr),
    .z0(zg0), .z1(zg1), .cnt0(cg0), .cnt1(cg1)
  );

  seq_det_sched #(.PAT_LEN(4), .PATTERN(4'b1110), .CNT_W(2)) u_s (
    .clock(clk), .reset(rst), .bus(ifs), .clear(clr),
    .z0(zs0), .z1(zs1), .cnt0(cs0), .cnt1(cs1)
  );

  typedef struct {
    logic       rst, r0, d0, r1, d1, clr;
    logic       g0, g1, z0, z1;
    logic [7:0] c0, c1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rs, r0, d0, r1, d1, cl,
                              input logic g0, g1, z0, z1, input logic [7:0] c0, c1);
    vec_t v;
    v.rst = rs; v.r0 = r0; v.d0 = d0; v.r1 = r1; v.d1 = d1; v.clr = cl;
    v.g0 = g0; v.g1 = g1; v.z0 = z0; v.z1 = z1; v.c0 = c0; v.c1 = c1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rs, r0, d0, r1, d1, cl);
    rst = rs; req0 = r0; x0 = d0; req1 = r1; x1 = d1; clr = cl;
  endtask

  task automatic cycle_end();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset state
    vecs.push_back(mk(1,0,0,0,0,0, 0,0, 0,0, 0,0));
    // channel 0 alone: 1,1,1,0
    vecs.push_back(mk(0,1,1,0,0,0, 1,0, 0,0, 0,0));
    vecs.push_back(mk(0,1,1,0,0,0, 1,0, 0,0, 0,0));
    vecs.push_back(mk(0,1,1,0,0,0, 1,0, 0,0, 0,0));
    vecs.push_back(mk(0,1,0,0,0,0, 1,0, 1,0, 1,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0, 0,0, 1,0));
    vecs.push_back(mk(1,0,0,0,0,0, 0,0, 0,0, 0,0));
    // contention: ch0 1,1,1,0 and ch1 0,0,0,0, each source holds its bit until granted
    vecs.push_back(mk(0,1,1,1,0,0, 1,0, 0,0, 0,0));
    vecs.push_back(mk(0,1,1,1,0,0, 0,1, 0,0, 0,0));
    vecs.push_back(mk(0,1,1,1,0,0, 1,0, 0,0, 0,0));
    vecs.push_back(mk(0,1,1,1,0,0, 0,1, 0,0, 0,0));
    vecs.push_back(mk(0,1,1,1,0,0, 1,0, 0,0, 0,0));
    vecs.push_back(mk(0,1,0,1,0,0, 0,1, 0,0, 0,0));
    vecs.push_back(mk(0,1,0,1,0,0, 1,0, 1,0, 1,0));
    vecs.push_back(mk(0,0,0,1,0,0, 0,1, 0,0, 1,0));
    // second match takes cnt0 to 2, then clear collides with a match
    vecs.push_back(mk(0,1,1,0,0,0, 1,0, 0,0, 1,0));
    vecs.push_back(mk(0,1,1,0,0,0, 1,0, 0,0, 1,0));
    vecs.push_back(mk(0,1,1,0,0,0, 1,0, 0,0, 1,0));
    vecs.push_back(mk(0,1,0,0,0,0, 1,0, 1,0, 2,0));
    vecs.push_back(mk(0,1,1,0,0,0, 1,0, 0,0, 2,0));
    vecs.push_back(mk(0,1,1,0,0,0, 1,0, 0,0, 2,0));
    vecs.push_back(mk(0,1,1,0,0,0, 1,0, 0,0, 2,0));
    vecs.push_back(mk(0,1,0,0,0,1, 1,0, 1,0, 0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0, 0,0, 0,0));
    // mid-stream reset after 1,1,1; gnt still follows req while reset is high
    vecs.push_back(mk(1,0,0,0,0,0, 0,0, 0,0, 0,0));
    vecs.push_back(mk(0,1,1,0,0,0, 1,0, 0,0, 0,0));
    vecs.push_back(mk(0,1,1,0,0,0, 1,0, 0,0, 0,0));
    vecs.push_back(mk(0,1,1,0,0,0, 1,0, 0,0, 0,0));
    vecs.push_back(mk(1,1,0,0,0,0, 1,0, 0,0, 0,0));
    vecs.push_back(mk(0,1,0,1,0,0, 1,0, 0,0, 0,0));
    vecs.push_back(mk(0,0,0,1,0,0, 0,1, 0,0, 0,0));
    vecs.push_back(mk(0,1,1,0,0,0, 1,0, 0,0, 0,0));
    vecs.push_back(mk(0,1,1,0,0,0, 1,0, 0,0, 0,0));
    vecs.push_back(mk(0,1,1,0,0,0, 1,0, 0,0, 0,0));
    vecs.push_back(mk(0,1,0,0,0,0, 1,0, 1,0, 1,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0, 0,0, 1,0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].r0, vecs[i].d0, vecs[i].r1, vecs[i].d1, vecs[i].clr);
      #1;
      chk($sformatf("row%0d gnt0", i), ifa.gnt0, vecs[i].g0);
      chk($sformatf("row%0d gnt1", i), ifa.gnt1, vecs[i].g1);
      cycle_end();
      chk($sformatf("row%0d z0", i), za0, vecs[i].z0);
      chk($sformatf("row%0d z1", i), za1, vecs[i].z1);
      chk($sformatf("row%0d cnt0", i), ca0, vecs[i].c0);
      chk($sformatf("row%0d cnt1", i), ca1, vecs[i].c1);
    end

    // fill guard with PATTERN 0001: a leading 1 after reset must not match
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle_end();
    chk("guard reset cnt0", cg0, 0);
    begin
      logic [4:0] bits;
      bits = 5'b10001;
      for (int i = 4; i >= 0; i--) begin
        drive(1'b0, 1'b1, bits[i], 1'b0, 1'b0, 1'b0);
        cycle_end();
        chk($sformatf("guard bit%0d z0", 4 - i), zg0, (i == 0));
      end
    end
    chk("guard cnt0", cg0, 1);
    chk("guard z1", zg1, 0);

    // saturation with a 2-bit counter on channel 1
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle_end();
    chk("sat reset cnt1", cs1, 0);
    begin
      logic [3:0] pat;
      pat = 4'b1110;
      for (int k = 1; k <= 5; k++) begin
        for (int b = 3; b >= 0; b--) begin
          drive(1'b0, 1'b0, 1'b0, 1'b1, pat[b], 1'b0);
          cycle_end();
          chk($sformatf("sat seq%0d bit%0d z1", k, 3 - b), zs1, (b == 0));
        end
        chk($sformatf("sat seq%0d cnt1", k), cs1, (k > 3) ? 3 : k);
      end
    end
    chk("sat cnt0", cs0, 0);

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_det_sched.md
# seq_det_sched

Two-channel scheduler for the shared serial sequence detector. Two serial bit sources request service through the block. A round-robin arbiter grants one source per clock. The block keeps a separate detection context (bit history plus fill count) for each source, so one detection engine serves both streams without the streams corrupting each other. Per-channel match pulses and saturating match counters go to the status/readout logic.

## Interface
Parameters:
- PAT_LEN, 4: pattern length in bits, legal range 2..8.
- PATTERN, 4'b1110: target sequence, MSB is the oldest bit.
- CNT_W, 8: width of each match counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising clock edge.
- req0  in  1  channel 0 has a valid bit this cycle.
- x0  in  1  channel 0 serial data bit.
- req1  in  1  channel 1 has a valid bit this cycle.
- x1  in  1  channel 1 serial data bit.
- clear  in  1  synchronous clear of both match counters.
- gnt0  out  1  combinational; x0 is consumed this cycle.
- gnt1  out  1  combinational; x1 is consumed this cycle.
- z0  out  1  registered one-cycle match pulse, channel 0.
- z1  out  1  registered one-cycle match pulse, channel 1.
- cnt0  out  CNT_W  channel 0 match count, saturating.
- cnt1  out  CNT_W  channel 1 match count, saturating.

## Operation
Arbiter:
- 1-bit pointer `last`. Values: LAST0 (channel 0 served last) or LAST1.
- Reset value is LAST1, so channel 0 wins the first conflict.
- Only req0 asserted: gnt0=1. Only req1 asserted: gnt1=1. Neither asserted: no grant.
- Both asserted: grant the channel the pointer does not name.
- The pointer updates only on a cycle that has a grant; it is set to the granted channel.
- gnt0 and gnt1 are never both 1. A source holds its request and bit until it sees its grant.

Per-channel context (hist, fill):
- hist is PAT_LEN-1 bits. fill is a 0..PAT_LEN-1 counter.
- On a grant, form win = {hist, x}.
- Then update hist <= win[PAT_LEN-2:0]. fill increments and saturates at PAT_LEN-1.
- match = (win == PATTERN) && (fill == PAT_LEN-1). The fill guard stops the zero-filled history after reset from producing false matches.
- Overlapping matches count. Example: with PATTERN 1010, the stream 101010 gives two matches.
- The context of the non-granted channel is held unchanged.

Outputs:
- z<n> <= match on channel n in the grant cycle; the register is 0 otherwise.
- cnt<n> increments on match and saturates at 2^CNT_W-1 (no wrap).
- clear zeroes both counters. If clear and a match occur in the same cycle, clear wins: the counter goes to 0, but z still pulses.
- clear does not affect hist, fill, the pointer, or z.

Reset:
- Takes effect at the next rising edge. Mid-stream reset discards all contexts.
- Reset state: hist=0, fill=0, pointer=LAST1, z0=z1=0, cnt0=cnt1=0.
- gnt outputs follow req combinationally, including during reset, but no state is committed while reset=1.

## Timing
- Grant: same cycle as the request (combinational path req -> gnt).
- Match latency: z<n> rises at the first rising edge after the grant cycle that carries the final pattern bit, and lasts exactly one cycle unless the next grant to that channel also matches.
- cnt<n> updates on the same edge as z<n>.
- Throughput: one bit per cycle in aggregate. Under continuous contention each channel gets one bit every 2 cycles.
- No combinational path from x0/x1 to any output.

## Test plan
- Reset then only req0 with bits 1,1,1,0 on 4 consecutive cycles -> gnt0=1 every cycle; z0 pulses for 1 cycle after the 4th grant; cnt0=1; z1=0, cnt1=0.
- req0 and req1 both held high, x0 stream 1,1,1,0 and x1 stream 0,0,0,0 -> grants alternate 0,1,0,1,...; z0 pulses after channel 0's 4th grant (cycle 8); cnt0=1, cnt1=0.
- Guard check with PATTERN=4'b0001: single channel, bits 1 right after reset -> no z (fill<3); then bits 0,0,0,1 -> z on the 4th.
- Saturation with CNT_W=2: 5 back-to-back 1110 sequences on channel 1 -> cnt1 reads 1,2,3,3,3; z1 pulses all 5 times.
- clear asserted in the same cycle as a matching grant, with cnt0=2 -> z0=1 next cycle; cnt0=0.
- Reset asserted after channel 0 has received 1,1,1; then 0 is sent -> no z0; fill restarts at 0.
